// File: rtl/south_input_router.sv
// South input-port controller of a 4x4 XY mesh router.
// Pops flits from the south input FIFO, routes each packet by its header,
// requests the chosen output port from the switch allocator and forwards
// the header plus LEN body flits across the crossbar. Illegal U-turn
// packets (destination further south on this column) are drained and dropped.
module south_input_router #(
    parameter logic [1:0] MY_X = 2'd1,
    parameter logic [1:0] MY_Y = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic [4:0] req,
    input  logic       gnt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       route_err
);

    // One-hot output ports as seen by the switch allocator.
    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_W = 5'b10000;

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        REQ,
        SEND,
        BODY_POP,
        BODY_WAIT,
        DROP_POP,
        DROP_WAIT
    } state_t;

    state_t     state_q;
    logic [3:0] rem_q;        // body flits still to be popped
    logic [7:0] hdr_q;        // header held until the port is granted
    logic [4:0] req_q;
    logic       pending_q;    // out_data_q holds a flit not yet transferred
    logic [7:0] out_data_q;
    logic       route_err_q;

    logic [4:0] route_d;      // req_q value for the header on fifo_data
    logic       route_ok_d;   // header does not ask for a U-turn
    logic       xfer;

    // Decode the XY output port of the header currently on fifo_data.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        route_d    = '0;
        route_ok_d = 1'b1;
        if (fifo_data[3:2] > MY_X) begin
            route_d = PORT_E;
        end else if (fifo_data[3:2] < MY_X) begin
            route_d = PORT_W;
        end else if (fifo_data[1:0] > MY_Y) begin
            route_d = PORT_N;
        end else if (fifo_data[1:0] == MY_Y) begin
            route_d = PORT_L;
        end else begin
            route_ok_d = 1'b0;
        end
    end

    // The pop must reach the FIFO in the same cycle the FSM decides to read,
    // so fifo_rd is decoded from state; a pop only happens from states where
    // no flit is pending, and never during reset or while the FIFO is empty.
    assign fifo_rd = !rst && !fifo_empty &&
                     (state_q == IDLE || state_q == BODY_POP || state_q == DROP_POP);

    // A pending flit is only offered while the allocator keeps the grant;
    // losing the grant hides the flit without discarding it.
    assign out_valid = pending_q && gnt;
    assign xfer      = out_valid && out_ready;

    assign req       = req_q;
    assign out_data  = out_data_q;
    assign route_err = route_err_q;

    // Packet FSM: header decode, port request, flit forwarding and dropping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            hdr_q       <= '0;
            req_q       <= '0;
            pending_q   <= 1'b0;
            out_data_q  <= '0;
            route_err_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees the values from before this clock edge.
            route_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    hdr_q <= fifo_data;
                    rem_q <= fifo_data[7:4];
                    if (route_ok_d) begin
                        req_q   <= route_d;
                        state_q <= REQ;
                    end else begin
                        route_err_q <= 1'b1;
                        state_q     <= (fifo_data[7:4] != 4'd0) ? DROP_POP : IDLE;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        out_data_q <= hdr_q;
                        pending_q  <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        pending_q <= 1'b0;
                        if (rem_q == 4'd0) begin
                            req_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= BODY_POP;
                        end
                    end
                end
                BODY_POP: begin
                    if (!fifo_empty) begin
                        state_q <= BODY_WAIT;
                    end
                end
                BODY_WAIT: begin
                    out_data_q <= fifo_data;
                    pending_q  <= 1'b1;
                    rem_q      <= rem_q - 4'd1;
                    state_q    <= SEND;
                end
                DROP_POP: begin
                    if (!fifo_empty) begin
                        rem_q   <= rem_q - 4'd1;
                        state_q <= DROP_WAIT;
                    end
                end
                DROP_WAIT: begin
                    state_q <= (rem_q == 4'd0) ? IDLE : DROP_POP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_south_input_router.sv
// Directed bench for south_input_router (MY_X=1, MY_Y=1).
// A simple FIFO model feeds the DUT; a negedge monitor keeps running totals
// of transfers, pops and error pulses that each test compares against.
module tb_south_input_router;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic [4:0] req;
    logic       gnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       route_err;

    south_input_router #(.MY_X(2'd1), .MY_Y(2'd1)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .req        (req),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .route_err  (route_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: registered output, data valid the cycle after the pop.
    logic [7:0] mem [0:1023];
    int         wr_ptr;
    int         rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Pop one flit into the registered output on each fifo_rd.
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Running totals, sampled mid-cycle when DUT outputs are stable.
    logic [7:0] log_q [0:1023];
    int log_n = 0, pop_n = 0, err_n = 0, valid_n = 0, bad_rd_n = 0;
    int req_hits [5] = '{0, 0, 0, 0, 0};

    // Accumulate transfers, pops, errors and requested ports.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                log_q[log_n] <= out_data;
                log_n        <= log_n + 1;
            end
            if (fifo_rd)               pop_n    <= pop_n + 1;
            if (fifo_rd && fifo_empty) bad_rd_n <= bad_rd_n + 1;
            if (route_err)             err_n    <= err_n + 1;
            if (out_valid)             valid_n  <= valid_n + 1;
            for (int b = 0; b < 5; b++) begin
                if (req[b]) req_hits[b] <= req_hits[b] + 1;
            end
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic wait_fifo_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fifo_rd) ok = 1'b1;
        end
    endtask

    task automatic wait_flit(input logic [7:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (out_valid && out_data == v) ok = 1'b1;
        end
    endtask

    function automatic logic [4:0] req_mask_since(input int base [5]);
        logic [4:0] m;
        for (int b = 0; b < 5; b++) m[b] = (req_hits[b] != base[b]);
        return m;
    endfunction

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] body_base;   // body flit i carries body_base + i
        logic [4:0] exp_req;
        logic       exp_err;
        int         exp_flits;
        int         exp_pops;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input int idx, input vec_t v);
        int len, b_log, b_pop, b_err, b_valid, b_bad;
        int b_req [5];
        logic [7:0] exp_flit;
        len     = int'(v.hdr[7:4]);
        b_log   = log_n;
        b_pop   = pop_n;
        b_err   = err_n;
        b_valid = valid_n;
        b_bad   = bad_rd_n;
        b_req   = req_hits;
        gnt       = 1'b1;
        out_ready = 1'b1;
        push(v.hdr);
        for (int i = 0; i < len; i++) push(v.body_base + 8'(i));
        repeat (64) @(negedge clk);
        #1;
        check($sformatf("v%0d flit count", idx), log_n - b_log, v.exp_flits);
        for (int j = 0; j < v.exp_flits && j < log_n - b_log; j++) begin
            exp_flit = (j == 0) ? v.hdr : v.body_base + 8'(j - 1);
            check($sformatf("v%0d flit %0d", idx, j), log_q[b_log + j], exp_flit);
        end
        check($sformatf("v%0d pops", idx), pop_n - b_pop, v.exp_pops);
        check($sformatf("v%0d route_err pulses", idx), err_n - b_err, v.exp_err);
        check($sformatf("v%0d req ports", idx), req_mask_since(b_req), v.exp_req);
        check($sformatf("v%0d pop while empty", idx), bad_rd_n - b_bad, 0);
        if (v.exp_err) check($sformatf("v%0d out_valid on drop", idx), valid_n - b_valid, 0);
        check($sformatf("v%0d req idle", idx), req, 5'b0);
        check($sformatf("v%0d out_valid idle", idx), out_valid, 1'b0);
    endtask

    initial begin
        bit ok;
        int cnt, b_log, b_pop;

        vecs[0]  = '{8'h09, 8'h00, 5'b00100, 1'b0,  1,  1};
        vecs[1]  = '{8'h27, 8'hA1, 5'b00010, 1'b0,  3,  3};
        vecs[2]  = '{8'h15, 8'h5A, 5'b00001, 1'b0,  2,  2};
        vecs[3]  = '{8'h14, 8'h11, 5'b00000, 1'b1,  0,  2};
        vecs[4]  = '{8'hF9, 8'h30, 5'b00100, 1'b0, 16, 16};
        vecs[5]  = '{8'h01, 8'h00, 5'b10000, 1'b0,  1,  1};
        vecs[6]  = '{8'h30, 8'hC0, 5'b10000, 1'b0,  4,  4};
        vecs[7]  = '{8'h2C, 8'hD0, 5'b00100, 1'b0,  3,  3};
        vecs[8]  = '{8'h04, 8'h00, 5'b00000, 1'b1,  0,  1};
        vecs[9]  = '{8'hF4, 8'h40, 5'b00000, 1'b1,  0, 16};
        vecs[10] = '{8'h06, 8'h00, 5'b00010, 1'b0,  1,  1};

        // Reset state, with a flit waiting that must not be popped.
        rst       = 1'b1;
        gnt       = 1'b0;
        out_ready = 1'b0;
        wr_ptr    = 0;
        repeat (2) @(negedge clk);
        push(8'h55);
        #1;
        check("reset fifo_rd", fifo_rd, 1'b0);
        check("reset req", req, 5'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 8'h00);
        check("reset route_err", route_err, 1'b0);
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst       = 1'b0;
        gnt       = 1'b1;
        out_ready = 1'b1;

        // Header latency and end-of-packet release for a LEN=0 east packet.
        @(posedge clk); #1;
        push(8'h09);
        wait_fifo_rd(10, ok);
        check("E hdr pop seen", ok, 1'b1);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            cnt++;
            if (out_valid) ok = 1'b1;
        end
        check("E hdr latency", cnt, 3);
        check("E out_data", out_data, 8'h09);
        check("E req", req, 5'b00100);
        @(negedge clk);
        check("E req after tail", req, 5'b0);
        check("E out_valid after tail", out_valid, 1'b0);
        check("E fifo_rd after tail", fifo_rd, 1'b0);

        // Backpressure on A1, then a grant drop on A2.
        b_log = log_n;
        b_pop = pop_n;
        @(posedge clk); #1;
        push(8'h27); push(8'hA1); push(8'hA2);
        wait_fifo_rd(10, ok);
        check("stall hdr pop seen", ok, 1'b1);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d out_valid", i), out_valid, 1'b1);
            check($sformatf("stall%0d out_data", i), out_data, 8'hA1);
            check($sformatf("stall%0d fifo_rd", i), fifo_rd, 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("nognt%0d out_valid", i), out_valid, 1'b0);
            check($sformatf("nognt%0d out_data", i), out_data, 8'hA2);
            check($sformatf("nognt%0d req", i), req, 5'b00010);
        end
        @(posedge clk); #1 gnt = 1'b1;
        @(negedge clk);
        check("regnt out_valid", out_valid, 1'b1);
        check("regnt out_data", out_data, 8'hA2);
        repeat (5) @(negedge clk);
        #1;
        check("stall flit count", log_n - b_log, 3);
        check("stall flit0", log_q[b_log], 8'h27);
        check("stall flit1", log_q[b_log + 1], 8'hA1);
        check("stall flit2", log_q[b_log + 2], 8'hA2);
        check("stall pops", pop_n - b_pop, 3);

        // FIFO runs dry mid-packet: the controller waits without popping.
        b_log = log_n;
        @(posedge clk); #1;
        push(8'h27); push(8'hA1);
        wait_flit(8'hA1, 20, ok);
        check("dry A1 seen", ok, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("dry%0d fifo_rd", i), fifo_rd, 1'b0);
            check($sformatf("dry%0d out_valid", i), out_valid, 1'b0);
            check($sformatf("dry%0d req", i), req, 5'b00010);
        end
        @(posedge clk); #1;
        push(8'hA2);
        wait_flit(8'hA2, 20, ok);
        check("dry A2 seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("dry flit count", log_n - b_log, 3);
        check("dry last flit", log_q[b_log + 2], 8'hA2);

        // Reset in the middle of the body clears every output at once.
        @(posedge clk); #1;
        push(8'h27); push(8'hA1); push(8'hA2);
        wait_flit(8'hA1, 20, ok);
        check("rst A1 seen", ok, 1'b1);
        #1;
        wr_ptr = rd_ptr;
        rst    = 1'b1;
        #1;
        check("midrst fifo_rd", fifo_rd, 1'b0);
        check("midrst req", req, 5'b0);
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst out_data", out_data, 8'h00);
        check("midrst route_err", route_err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst req", req, 5'b0);
        check("postrst fifo_rd", fifo_rd, 1'b0);

        // Table of whole packets under continuous grant and ready.
        for (int v = 0; v < 11; v++) begin
            @(posedge clk); #1;
            run_vec(v, vecs[v]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
